// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared constants and queue entry layout for the instruction fetch queue.
package inst_fetch_queue_pkg;
    localparam logic [31:0] IFQ_RESET_PC    = 32'hBFC0_0000;
    localparam int          IFQ_ENTRY_W     = 64;
    localparam logic [31:0] IFQ_FETCH_BYTES = 32'd8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifq_entry_t;
endpackage

// File: rtl/ifq_storage.sv
// ifq_storage: DEPTH-entry register array, two adjacent write slots and two adjacent async read slots.
module ifq_storage
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_wr_ptr,
    input  logic [IFQ_ENTRY_W-1:0]     i_wdata0,
    input  logic [IFQ_ENTRY_W-1:0]     i_wdata1,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_ptr,
    output logic [IFQ_ENTRY_W-1:0]     o_rdata0,
    output logic [IFQ_ENTRY_W-1:0]     o_rdata1
);
    localparam int AW = $clog2(DEPTH);

    logic [IFQ_ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_ptr]           <= i_wdata0;
            r_mem[i_wr_ptr + AW'(1)]  <= i_wdata1;
        end
    end

    assign o_rdata0 = r_mem[i_rd_ptr];
    assign o_rdata1 = r_mem[i_rd_ptr + AW'(1)];
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential fetch PC generator feeding a two-wide instruction FIFO for decode.
// IFQ_BYPASS_EN: empty-queue responses reach the outputs in the same cycle as inst_data_ok.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [63:0] inst_rdata,
    output logic        out_valid0,
    output logic        out_valid1,
    output logic [31:0] out_inst0,
    output logic [31:0] out_inst1,
    output logic [31:0] out_pc0,
    output logic [31:0] out_pc1,
    input  logic [1:0]  deq_num
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_fetch_pc;
    logic          r_outstanding;
    logic          r_discard;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;

    logic          w_accept;
    logic          w_resp;
    logic          w_enq;
    logic          w_byp;
    logic [31:0]   w_need;
    logic [31:0]   w_resp_pc;
    ifq_entry_t    w_wdata0;
    ifq_entry_t    w_wdata1;
    ifq_entry_t    w_rdata0;
    ifq_entry_t    w_rdata1;

    // Space is reserved for the in-flight pair so a response can always be enqueued.
    assign w_need    = 32'(r_count) + ((r_outstanding & ~r_discard) ? 32'd2 : 32'd0);
    assign inst_req  = rstn & ~flush & (~r_outstanding | inst_data_ok) & (w_need <= 32'(DEPTH - 2));
    assign inst_addr = r_fetch_pc;
    assign w_accept  = inst_req & inst_addr_ok;
    assign w_resp    = inst_data_ok & r_outstanding;
    assign w_enq     = w_resp & ~r_discard & ~flush;
    // Only one request is in flight, so its address is one fetch block behind fetch_pc.
    assign w_resp_pc = r_fetch_pc - IFQ_FETCH_BYTES;
    assign w_wdata0  = '{pc: w_resp_pc, inst: inst_rdata[31:0]};
    assign w_wdata1  = '{pc: w_resp_pc + 32'd4, inst: inst_rdata[63:32]};

    ifq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk      (clk),
        .i_we     (w_enq),
        .i_wr_ptr (r_wr_ptr),
        .i_wdata0 (w_wdata0),
        .i_wdata1 (w_wdata1),
        .i_rd_ptr (r_rd_ptr),
        .o_rdata0 (w_rdata0),
        .o_rdata1 (w_rdata1)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else if (flush) begin
            r_fetch_pc    <= flush_pc;
            r_outstanding <= r_outstanding & ~inst_data_ok;
            r_discard     <= r_outstanding & ~inst_data_ok;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            if (w_accept) begin
                r_fetch_pc    <= r_fetch_pc + IFQ_FETCH_BYTES;
                r_outstanding <= 1'b1;
                r_discard     <= 1'b0;
            end else if (w_resp) begin
                r_outstanding <= 1'b0;
            end
            // A bypassed pair is written too; the same-cycle dequeue retires whatever decode took.
            if (w_enq)
                r_wr_ptr <= r_wr_ptr + AW'(2);
            r_rd_ptr <= r_rd_ptr + AW'(deq_num);
            r_count  <= r_count + (w_enq ? CW'(2) : CW'(0)) - CW'(deq_num);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && w_enq)
            assert (r_count <= CW'(DEPTH - 2));
    end

`ifdef IFQ_BYPASS_EN
    assign w_byp = w_enq & (r_count == '0);
`else
    assign w_byp = 1'b0;
`endif

    assign out_valid0 = w_byp | (r_count >= CW'(1));
    assign out_valid1 = w_byp | (r_count >= CW'(2));
    assign out_inst0  = w_byp ? w_wdata0.inst : w_rdata0.inst;
    assign out_pc0    = w_byp ? w_wdata0.pc   : w_rdata0.pc;
    assign out_inst1  = w_byp ? w_wdata1.inst : w_rdata1.inst;
    assign out_pc1    = w_byp ? w_wdata1.pc   : w_rdata1.pc;
endmodule
